// File: rtl/pmem_write_buffer_pkg.sv
// pmem_write_buffer_pkg: shared types and constants for the eviction write buffer
package pmem_write_buffer_pkg;
  localparam int LINE_OFFSET_BITS = 5;
  typedef logic [255:0] line_t;
  typedef logic [15:0] addr_t;
  typedef logic [10:0] index_t;
  typedef enum logic [2:0] {IDLE, RESP, RD_MISS, RD_DONE, DRAIN} state_t;
endpackage

// File: rtl/pmem_write_buffer_if.sv
// pmem_write_buffer_if: L1-side and memory-side bus of the write buffer
// slave: the buffer (takes L1 requests and memory responses)
// master: the L1 cache plus physical memory surrounding it
interface pmem_write_buffer_if;
  import pmem_write_buffer_pkg::*;
  logic mem_read, mem_write, mem_resp, pmem_read, pmem_write, pmem_resp;
  addr_t mem_address, pmem_address;
  line_t mem_wdata, mem_rdata, pmem_wdata, pmem_rdata;
  modport slave(input mem_read, mem_write, mem_address, mem_wdata, pmem_resp, pmem_rdata,
                output mem_resp, mem_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata);
  modport master(output mem_read, mem_write, mem_address, mem_wdata, pmem_resp, pmem_rdata,
                 input mem_resp, mem_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata);
endinterface

// File: rtl/pmem_write_buffer_entry_array.sv
// pwb_entry_array: DEPTH line entries with parallel index match and a head read port
// i_we/i_wptr/i_windex/i_wline: write (sets valid); i_inv/i_inv_ptr: invalidate
// i_lookup -> o_hit/o_hit_ptr/o_hit_line; i_head -> o_head_index/o_head_line
import pmem_write_buffer_pkg::*;
module pwb_entry_array #(parameter int DEPTH = 4) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_we,
  input  logic [$clog2(DEPTH)-1:0]   i_wptr,
  input  index_t                     i_windex,
  input  line_t                      i_wline,
  input  logic                       i_inv,
  input  logic [$clog2(DEPTH)-1:0]   i_inv_ptr,
  input  index_t                     i_lookup,
  input  logic [$clog2(DEPTH)-1:0]   i_head,
  output logic                       o_hit,
  output logic [$clog2(DEPTH)-1:0]   o_hit_ptr,
  output line_t                      o_hit_line,
  output index_t                     o_head_index,
  output line_t                      o_head_line
);
  localparam int PW = $clog2(DEPTH);
  logic [DEPTH-1:0] r_valid;
  index_t r_index [DEPTH];
  line_t r_line [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) r_valid <= '0;
    else begin
      if (i_we) begin
        r_valid[i_wptr] <= 1'b1;
        r_index[i_wptr] <= i_windex;
        r_line[i_wptr] <= i_wline;
      end
      if (i_inv) r_valid[i_inv_ptr] <= 1'b0;
    end
  end
  // indices are unique, so at most one entry can match
  always_comb begin
    o_hit = 1'b0;
    o_hit_ptr = '0;
    for (int i = 0; i < DEPTH; i++)
      if (r_valid[i] && r_index[i] == i_lookup) begin
        o_hit = 1'b1;
        o_hit_ptr = PW'(i);
      end
  end
  assign o_hit_line = r_line[o_hit_ptr];
  assign o_head_index = r_index[i_head];
  assign o_head_line = r_line[i_head];
endmodule

// File: rtl/pmem_write_buffer.sv
// pmem_write_buffer: eviction write buffer between L1 memory port and physical memory
// clk/rst: clock, synchronous active-high reset; bus: L1 (mem_*) and memory (pmem_*) sides
// PMEM_WRITE_BUFFER_READ_FWD_EN: serve read hits from the buffer instead of draining first
import pmem_write_buffer_pkg::*;
module pmem_write_buffer #(parameter int DEPTH = 4) (
  input logic clk,
  input logic rst,
  pmem_write_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  state_t r_state, w_next;
  logic [PW-1:0] r_head, r_tail, w_hit_ptr;
  logic [PW:0] r_count;
  line_t r_rdata, r_pwdata, w_hit_line, w_head_line;
  addr_t r_paddr;
  index_t w_index, w_head_index;
  logic w_hit, w_we, w_deq, w_full, w_fwd, w_load, w_unused;
`ifdef PMEM_WRITE_BUFFER_READ_FWD_EN
  assign w_fwd = 1'b1;
`else
  assign w_fwd = 1'b0;
`endif
  assign w_unused = &{1'b0, bus.mem_address[LINE_OFFSET_BITS-1:0]};
  assign w_index = bus.mem_address[15:LINE_OFFSET_BITS];
  assign w_full = r_count == (PW+1)'(DEPTH);
  pwb_entry_array #(.DEPTH(DEPTH)) u_arr (
    .clk(clk), .rst(rst),
    .i_we(w_we), .i_wptr(w_hit ? w_hit_ptr : r_tail), .i_windex(w_index), .i_wline(bus.mem_wdata),
    .i_inv(w_deq), .i_inv_ptr(r_head), .i_lookup(w_index), .i_head(r_head),
    .o_hit(w_hit), .o_hit_ptr(w_hit_ptr), .o_hit_line(w_hit_line),
    .o_head_index(w_head_index), .o_head_line(w_head_line)
  );
  // a write to a full buffer drains first and is retried on return to IDLE
  always_comb begin
    w_next = r_state;
    w_we = 1'b0;
    w_deq = 1'b0;
    case (r_state)
      IDLE:
        if (bus.mem_write) begin
          w_we = w_hit || !w_full;
          w_next = w_we ? RESP : DRAIN;
        end else if (bus.mem_read) w_next = !w_hit ? RD_MISS : w_fwd ? RESP : DRAIN;
        else if (r_count != '0) w_next = DRAIN;
      RESP: w_next = IDLE;
      RD_MISS: w_next = bus.pmem_resp ? RD_DONE : RD_MISS;
      RD_DONE: w_next = RESP;
      DRAIN: begin
        w_deq = bus.pmem_resp;
        w_next = bus.pmem_resp ? IDLE : DRAIN;
      end
      default: w_next = IDLE;
    endcase
  end
  assign w_load = (r_state == IDLE && !bus.mem_write && bus.mem_read && w_hit && w_fwd) ||
                  (r_state == RD_MISS && bus.pmem_resp);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
      r_rdata <= '0;
      r_paddr <= '0;
      r_pwdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) r_rdata <= r_state == RD_MISS ? bus.pmem_rdata : w_hit_line;
      if (r_state == IDLE && w_next == RD_MISS) r_paddr <= {w_index, {LINE_OFFSET_BITS{1'b0}}};
      // drain address/data are captured once so they stay frozen for the transaction
      if (r_state == IDLE && w_next == DRAIN) begin
        r_paddr <= {w_head_index, {LINE_OFFSET_BITS{1'b0}}};
        r_pwdata <= w_head_line;
      end
      if (w_we && !w_hit) begin
        r_tail <= r_tail + 1'b1;
        r_count <= r_count + 1'b1;
      end
      if (w_deq) begin
        r_head <= r_head + 1'b1;
        r_count <= r_count - 1'b1;
      end
    end
  end
  assign bus.mem_resp = r_state == RESP;
  assign bus.mem_rdata = r_rdata;
  assign bus.pmem_read = r_state == RD_MISS;
  assign bus.pmem_write = r_state == DRAIN;
  assign bus.pmem_address = r_paddr;
  assign bus.pmem_wdata = r_pwdata;
endmodule
